sd_cmd_arbiter: RTL and testbench

SD_CMD_ARBITER -- requirements
Module: sd_cmd_arbiter

---
 rtl/sd_cmd_arbiter_pkg.sv | 22 ++
 rtl/sd_cmd_tout_cnt.sv | 26 ++
 rtl/sd_cmd_arbiter.sv | 121 ++++++++++++
 tb/tb_sd_cmd_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_arbiter_pkg.sv
// Shared types for the SD command-slot arbiter: FSM state encoding, owner
// indices and the round-robin pick helper.
package sd_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT     = 2'd2,
    ST_COMPLETE = 2'd3
  } arb_state_e;

  localparam logic OWNER_SW = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  // A tie goes to whichever side did not own the slot last time.
  function automatic logic pick_owner(input logic sw_req, input logic dm_req,
                                      input logic last_owner);
    if (sw_req && dm_req) return ~last_owner;
    return dm_req ? OWNER_DM : OWNER_SW;
  endfunction

endpackage

// File: rtl/sd_cmd_tout_cnt.sv
// Completion timeout counter: counts enabled cycles from zero, saturates, and
// flags expiry on the cycle where count reaches limit-1 (limit 0 disables).
module sd_cmd_tout_cnt #(
  parameter int TOUT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [TOUT_W-1:0] limit,
  output logic              expire
);

  logic [TOUT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + TOUT_W'(1);
    end
  end

  assign expire = enable && (limit != '0) && (count == (limit - TOUT_W'(1)));

endmodule

// File: rtl/sd_cmd_arbiter.sv
// Arbitrates the SD command engine between the software and data-master
// requesters, issues one command at a time and reports completion/timeout.
module sd_cmd_arbiter
  import sd_cmd_arbiter_pkg::*;
#(
  parameter int TOUT_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              sw_req_i,
  input  logic [15:0]       sw_cmd_set_i,
  input  logic [31:0]       sw_cmd_arg_i,
  output logic              sw_ack_o,
  output logic              sw_done_o,
  input  logic              dm_req_i,
  input  logic [15:0]       dm_cmd_set_i,
  input  logic [31:0]       dm_cmd_arg_i,
  output logic              dm_ack_o,
  output logic              dm_done_o,
  input  logic [TOUT_W-1:0] tout_i,
  input  logic              cmd_done_i,
  input  logic              cmd_err_i,
  output logic              new_cmd_o,
  output logic [15:0]       cmd_setting_o,
  output logic [31:0]       argument_o,
  output logic              owner_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              tout_err_o,
  output arb_state_e        dbg_state
);

  // Handshake: a requester holds req high (level) with set/arg stable until it
  // sees its ack pulse; set/arg are captured on the grant edge, so the
  // requester may change them or drop req in the ack cycle. Exactly one done
  // pulse follows each ack unless reset intervenes.

  arb_state_e state, state_next;
  logic       grant;
  logic       owner_next;
  logic       tout_hit;
  logic       expire;
  logic       err_q;
  logic       tout_q;

  sd_cmd_tout_cnt #(.TOUT_W(TOUT_W)) u_tout_cnt (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_i),
    .clear  (state != ST_WAIT),
    .enable (state == ST_WAIT),
    .limit  (tout_i),
    .expire (expire)
  );

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    owner_next = owner_o;
    tout_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sw_req_i || dm_req_i) begin
          grant      = 1'b1;
          owner_next = pick_owner(sw_req_i, dm_req_i, owner_o);
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = cmd_done_i ? ST_COMPLETE : ST_WAIT;
      end
      ST_WAIT: begin
        // A completion arriving on the expiry cycle takes precedence.
        if (cmd_done_i) begin
          state_next = ST_COMPLETE;
        end else if (expire) begin
          state_next = ST_COMPLETE;
          tout_hit   = 1'b1;
        end
      end
      ST_COMPLETE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state         <= ST_IDLE;
      cmd_setting_o <= '0;
      argument_o    <= '0;
      owner_o       <= OWNER_DM;
      err_q         <= 1'b0;
      tout_q        <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        owner_o       <= owner_next;
        cmd_setting_o <= (owner_next == OWNER_DM) ? dm_cmd_set_i : sw_cmd_set_i;
        argument_o    <= (owner_next == OWNER_DM) ? dm_cmd_arg_i : sw_cmd_arg_i;
      end
      if (state_next == ST_COMPLETE) begin
        err_q  <= cmd_done_i ? cmd_err_i : 1'b1;
        tout_q <= tout_hit;
      end
    end
  end

  assign new_cmd_o  = (state == ST_ISSUE);
  assign sw_ack_o   = (state == ST_ISSUE) && (owner_o == OWNER_SW);
  assign dm_ack_o   = (state == ST_ISSUE) && (owner_o == OWNER_DM);
  assign sw_done_o  = (state == ST_COMPLETE) && (owner_o == OWNER_SW);
  assign dm_done_o  = (state == ST_COMPLETE) && (owner_o == OWNER_DM);
  assign err_o      = (state == ST_COMPLETE) && err_q;
  assign tout_err_o = (state == ST_COMPLETE) && tout_q;
  assign busy_o     = (state != ST_IDLE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Self-checking bench for sd_cmd_arbiter: directed scenarios plus a random
// command loop, with issue/done expectations queued when stimulus is driven.
module tb_sd_cmd_arbiter;
  import sd_cmd_arbiter_pkg::*;

  localparam int TOUT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sw_req = 1'b0, dm_req = 1'b0;
  logic [15:0]       sw_set = '0, dm_set = '0;
  logic [31:0]       sw_arg = '0, dm_arg = '0;
  logic [TOUT_W-1:0] tout = '0;
  logic              cmd_done = 1'b0, cmd_err = 1'b0;
  logic              sw_ack, sw_done, dm_ack, dm_done;
  logic              new_cmd, owner, busy, err, tout_err;
  logic [15:0]       cmd_setting;
  logic [31:0]       argument;
  arb_state_e        dbg_state;

  always #5 clk = ~clk;

  sd_cmd_arbiter #(.TOUT_W(TOUT_W)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst_n),
    .sw_req_i      (sw_req),
    .sw_cmd_set_i  (sw_set),
    .sw_cmd_arg_i  (sw_arg),
    .sw_ack_o      (sw_ack),
    .sw_done_o     (sw_done),
    .dm_req_i      (dm_req),
    .dm_cmd_set_i  (dm_set),
    .dm_cmd_arg_i  (dm_arg),
    .dm_ack_o      (dm_ack),
    .dm_done_o     (dm_done),
    .tout_i        (tout),
    .cmd_done_i    (cmd_done),
    .cmd_err_i     (cmd_err),
    .new_cmd_o     (new_cmd),
    .cmd_setting_o (cmd_setting),
    .argument_o    (argument),
    .owner_o       (owner),
    .busy_o        (busy),
    .err_o         (err),
    .tout_err_o    (tout_err),
    .dbg_state     (dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  // {sw_ack, dm_ack, owner, setting, argument}
  logic [50:0] exp_q[$];
  // {sw_done, dm_done, err, tout_err}
  logic [3:0]  exp_done_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every issue/done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (new_cmd || sw_ack || dm_ack) begin
        if (exp_q.size() == 0)
          check("unexp_issue", {new_cmd, sw_ack, dm_ack}, 0);
        else
          check("issue", {new_cmd, sw_ack, dm_ack, owner, cmd_setting, argument},
                {1'b1, exp_q.pop_front()});
      end
      if (sw_done || dm_done || tout_err) begin
        if (exp_done_q.size() == 0)
          check("unexp_done", {sw_done, dm_done, tout_err}, 0);
        else
          check("done", {sw_done, dm_done, err, tout_err}, exp_done_q.pop_front());
      end
      if (err && !(sw_done || dm_done)) check("stray_err", err, 0);
    end
  end

  task automatic wait_idle(input int bound);
    int n = 0;
    @(negedge clk);
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_wait", busy, 0);
  endtask

  task automatic pulse_done(input int delay, input logic e);
    repeat (delay) @(posedge clk);
    #1 cmd_done = 1'b1; cmd_err = e;
    @(posedge clk);
    #1 cmd_done = 1'b0; cmd_err = 1'b0;
  endtask

  // One command from a single requester; done driven d cycles after ISSUE
  // (d=0 lands in ISSUE, d=k in the k-th WAIT cycle).
  task automatic do_cmd(input logic is_dm, input logic [15:0] set, input logic [31:0] arg,
                        input logic [TOUT_W-1:0] t, input int d, input logic e);
    logic exp_err, exp_tout;
    wait_idle(100);
    @(posedge clk);
    #1 tout = t;
    if (is_dm) begin dm_req = 1'b1; dm_set = set; dm_arg = arg; end
    else begin sw_req = 1'b1; sw_set = set; sw_arg = arg; end
    exp_tout = (t != 0) && (d > int'(t));
    exp_err  = exp_tout ? 1'b1 : e;
    exp_q.push_back({~is_dm, is_dm, is_dm, set, arg});
    exp_done_q.push_back({~is_dm, is_dm, exp_err, exp_tout});
    @(posedge clk);
    #1 sw_req = 1'b0; dm_req = 1'b0;
    sw_set = 16'($urandom); sw_arg = $urandom; dm_set = 16'($urandom); dm_arg = $urandom;
    check("grant", {sw_ack, dm_ack, new_cmd, busy, owner}, {~is_dm, is_dm, 1'b1, 1'b1, is_dm});
    pulse_done(d, e);
    wait_idle(100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 check("reset", {busy, sw_ack, dm_ack, new_cmd, sw_done, dm_done, err, tout_err,
                       owner, cmd_setting, argument}, {8'b0, 1'b1, 48'b0});
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Simultaneous requests after reset: sw first, dm in the following IDLE.
    @(posedge clk);
    #1 sw_req = 1'b1; dm_req = 1'b1; tout = '0;
    sw_set = 16'h0111; sw_arg = 32'hAAAA_0001; dm_set = 16'h0222; dm_arg = 32'hBBBB_0002;
    exp_q.push_back({1'b1, 1'b0, 1'b0, 16'h0111, 32'hAAAA_0001});
    exp_done_q.push_back(4'b1000);
    exp_q.push_back({1'b0, 1'b1, 1'b1, 16'h0222, 32'hBBBB_0002});
    exp_done_q.push_back(4'b0100);
    @(posedge clk);
    #1 check("rr_first", {sw_ack, dm_ack, owner}, 3'b100);
    pulse_done(2, 1'b0);
    repeat (2) @(posedge clk);
    #1 check("rr_second", {sw_ack, dm_ack, owner}, 3'b011);
    sw_req = 1'b0; dm_req = 1'b0;
    pulse_done(1, 1'b0);

    // Single sw request, completion 5 cycles after issue.
    do_cmd(1'b0, 16'h0119, 32'h0000_1000, '0, 5, 1'b0);

    // Timeout of 8: done pulse on ISSUE + 8 WAIT + 1, i.e. the 10th negedge.
    wait_idle(100);
    @(posedge clk);
    #1 dm_req = 1'b1; dm_set = 16'h0C0D; dm_arg = 32'h1234_5678; tout = 16'd8;
    exp_q.push_back({1'b0, 1'b1, 1'b1, 16'h0C0D, 32'h1234_5678});
    exp_done_q.push_back(4'b0111);
    @(posedge clk);
    #1 dm_req = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (dm_done) break;
    end
    check("tout_latency", n, 10);
    wait_idle(100);

    // Done with error on the timeout cycle: done wins, no tout_err.
    do_cmd(1'b1, 16'h0333, 32'hCAFE_0003, 16'd8, 8, 1'b1);
    // Done in ISSUE, done one cycle before timeout, timeout with late done ignored.
    do_cmd(1'b0, 16'h0444, 32'h0000_0004, 16'd4, 0, 1'b1);
    do_cmd(1'b1, 16'h0555, 32'h0000_0005, 16'd4, 3, 1'b0);
    do_cmd(1'b0, 16'h0666, 32'h0000_0006, 16'd1, 6, 1'b0);

    // Timeout disabled: still busy after 1000 cycles, then completes normally.
    wait_idle(100);
    @(posedge clk);
    #1 sw_req = 1'b1; sw_set = 16'h0777; sw_arg = 32'h7777_7777; tout = '0;
    exp_q.push_back({1'b1, 1'b0, 1'b0, 16'h0777, 32'h7777_7777});
    exp_done_q.push_back(4'b1000);
    @(posedge clk);
    #1 sw_req = 1'b0;
    repeat (1000) @(posedge clk);
    #1 check("no_abort", {busy, tout_err}, 2'b10);
    pulse_done(0, 1'b0);
    wait_idle(100);

    // Reset during WAIT discards the command; a later done is ignored.
    @(posedge clk);
    #1 dm_req = 1'b1; dm_set = 16'h0888; dm_arg = 32'h8888_0008; tout = '0;
    exp_q.push_back({1'b0, 1'b1, 1'b1, 16'h0888, 32'h8888_0008});
    @(posedge clk);
    #1 dm_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_mid", {busy, sw_ack, dm_ack, new_cmd, sw_done, dm_done, err, tout_err,
                      owner, cmd_setting, argument}, {8'b0, 1'b1, 48'b0});
    pulse_done(2, 1'b1);
    repeat (3) @(posedge clk);
    #1 check("rst_ignore", busy, 0);

    // Random single-requester commands.
    for (int i = 0; i < 12; i++) begin
      logic [TOUT_W-1:0] t;
      t = ($urandom_range(0, 2) == 0) ? '0 : TOUT_W'($urandom_range(1, 10));
      do_cmd(1'($urandom_range(0, 1)), 16'($urandom), $urandom, t,
             $urandom_range(0, 12), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    #1 check("issue_q_left", exp_q.size(), 0);
    check("done_q_left", exp_done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
